// File: rtl/register_file.sv
// Multi-ported register file: one byte-masked write port, two combinational
// read ports, optional hardwired-zero register 0 and optional write-to-read bypass.
module register_file #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 write,
  input  logic [ADDR_W-1:0]    writeAddr,
  input  logic [WIDTH/8-1:0]   byteEn,
  input  logic [WIDTH-1:0]     wordIn,
  input  logic [ADDR_W-1:0]    readAddrA,
  input  logic [ADDR_W-1:0]    readAddrB,
  output logic [WIDTH-1:0]     wordOutA,
  output logic [WIDTH-1:0]     wordOutB
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned NBYTE = WIDTH / 8;

  logic [WIDTH-1:0] regs [DEPTH];
  logic [WIDTH-1:0] merged;
  logic             wr_ok;

  // Read-side data selection shared by both ports: reset forces zero, register 0
  // may be hardwired, and the in-flight write may be forwarded.
  function automatic logic [WIDTH-1:0] read_port(
    input logic [ADDR_W-1:0] addr,
    input logic [WIDTH-1:0]  stored,
    input logic              rst,
    input logic              fwd_ok,
    input logic [ADDR_W-1:0] waddr,
    input logic [WIDTH-1:0]  fwd_data
  );
    if (rst)
      return '0;
    if (ZERO_REG != 0 && addr == '0)
      return '0;
    if (BYPASS != 0 && fwd_ok && addr == waddr)
      return fwd_data;
    return stored;
  endfunction

  // Merge enabled bytes of wordIn over the currently stored word; decide if the write lands.
  always_comb begin
    merged = regs[writeAddr];
    for (int unsigned i = 0; i < NBYTE; i++) begin
      if (byteEn[i])
        merged[8*i +: 8] = wordIn[8*i +: 8];
    end
    wr_ok = write && !reset && !(ZERO_REG != 0 && writeAddr == '0);
  end

  // Storage update: synchronous clear has priority over the single write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++)
        regs[i] <= '0;
    end else if (wr_ok) begin
      regs[writeAddr] <= merged;
    end
  end

  // Combinational read ports.
  always_comb begin
    wordOutA = read_port(readAddrA, regs[readAddrA], reset, wr_ok, writeAddr, merged);
    wordOutB = read_port(readAddrB, regs[readAddrB], reset, wr_ok, writeAddr, merged);
  end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: default instance, a BYPASS=0 instance
// sharing its stimulus, and a 64-bit / 8-entry instance.
module tb_register_file;

  logic        clk = 1'b0;
  logic        reset;
  logic        write;
  logic [4:0]  waddr, ra, rb;
  logic [3:0]  ben;
  logic [31:0] win;
  logic [31:0] outA, outB, oA1, oB1;

  logic        w64;
  logic [2:0]  waddr3, ra3, rb3;
  logic [7:0]  ben8;
  logic [63:0] win64, oA2, oB2;

  int compared   = 0;
  int mismatched = 0;
  logic [63:0] sb_q [$];
  logic [63:0] e;

  always #5 clk = ~clk;

  register_file #(.WIDTH(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) u0 (
    .clk(clk), .reset(reset), .write(write), .writeAddr(waddr), .byteEn(ben),
    .wordIn(win), .readAddrA(ra), .readAddrB(rb), .wordOutA(outA), .wordOutB(outB));

  register_file #(.WIDTH(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) u1 (
    .clk(clk), .reset(reset), .write(write), .writeAddr(waddr), .byteEn(ben),
    .wordIn(win), .readAddrA(ra), .readAddrB(rb), .wordOutA(oA1), .wordOutB(oB1));

  register_file #(.WIDTH(64), .ADDR_W(3), .ZERO_REG(1), .BYPASS(1)) u2 (
    .clk(clk), .reset(reset), .write(w64), .writeAddr(waddr3), .byteEn(ben8),
    .wordIn(win64), .readAddrA(ra3), .readAddrB(rb3), .wordOutA(oA2), .wordOutB(oB2));

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; write = 1'b0; waddr = '0; ben = '0; win = '0; ra = 5'd5; rb = 5'd5;
    w64 = 1'b0; waddr3 = '0; ben8 = '0; win64 = '0; ra3 = '0; rb3 = '0;
    step();
    sb_q.push_back(64'h0); sb_q.push_back(64'h0);
    @(negedge clk);
    compared++; e = sb_q.pop_front();
    if (outA !== e[31:0]) begin mismatched++; $display("FAIL reset_outA: got %h expected %h", outA, e[31:0]); end
    compared++; e = sb_q.pop_front();
    if (outB !== e[31:0]) begin mismatched++; $display("FAIL reset_outB: got %h expected %h", outB, e[31:0]); end
    step();
    reset = 1'b0;
    sb_q.push_back(64'h0);
    @(negedge clk);
    compared++; e = sb_q.pop_front();
    if (outA !== e[31:0]) begin mismatched++; $display("FAIL post_reset_reg5: got %h expected %h", outA, e[31:0]); end
    step();
  endtask

  task automatic test_basic_write;
    write = 1'b1; waddr = 5'd5; win = 32'h22100002; ben = 4'hF; ra = 5'd5;
    sb_q.push_back(64'h22100002); sb_q.push_back(64'h0);
    @(negedge clk);
    compared++; e = sb_q.pop_front();
    if (outA !== e[31:0]) begin mismatched++; $display("FAIL basic_bypass: got %h expected %h", outA, e[31:0]); end
    compared++; e = sb_q.pop_front();
    if (oA1 !== e[31:0]) begin mismatched++; $display("FAIL basic_nobypass_old: got %h expected %h", oA1, e[31:0]); end
    step();
    write = 1'b0;
    sb_q.push_back(64'h22100002);
    @(negedge clk);
    compared++; e = sb_q.pop_front();
    if (outA !== e[31:0]) begin mismatched++; $display("FAIL basic_readback: got %h expected %h", outA, e[31:0]); end
    step();
  endtask

  task automatic test_zero_reg;
    write = 1'b1; waddr = 5'd0; win = 32'hFFFFFFFF; ben = 4'hF; ra = 5'd0;
    sb_q.push_back(64'h0);
    @(negedge clk);
    compared++; e = sb_q.pop_front();
    if (outA !== e[31:0]) begin mismatched++; $display("FAIL zero_reg_write_cycle: got %h expected %h", outA, e[31:0]); end
    step();
    write = 1'b0;
    sb_q.push_back(64'h0); sb_q.push_back(64'h0);
    @(negedge clk);
    compared++; e = sb_q.pop_front();
    if (outA !== e[31:0]) begin mismatched++; $display("FAIL zero_reg_after: got %h expected %h", outA, e[31:0]); end
    compared++; e = sb_q.pop_front();
    if (oA1 !== e[31:0]) begin mismatched++; $display("FAIL zero_reg_after_nobypass: got %h expected %h", oA1, e[31:0]); end
    step();
  endtask

  task automatic test_byte_enable;
    write = 1'b1; waddr = 5'd7; win = 32'hAABBCCDD; ben = 4'hF;
    step();
    win = 32'h11223344; ben = 4'b0101; rb = 5'd7;
    sb_q.push_back(64'hAA22CC44);
    @(negedge clk);
    compared++; e = sb_q.pop_front();
    if (outB !== e[31:0]) begin mismatched++; $display("FAIL byteen_bypass_B: got %h expected %h", outB, e[31:0]); end
    step();
    write = 1'b0; ra = 5'd7;
    sb_q.push_back(64'hAA22CC44);
    @(negedge clk);
    compared++; e = sb_q.pop_front();
    if (outA !== e[31:0]) begin mismatched++; $display("FAIL byteen_stored: got %h expected %h", outA, e[31:0]); end
    step();
    write = 1'b1; win = 32'hFFFFFFFF; ben = 4'h0;
    sb_q.push_back(64'hAA22CC44);
    @(negedge clk);
    compared++; e = sb_q.pop_front();
    if (outA !== e[31:0]) begin mismatched++; $display("FAIL byteen_zero_cycle: got %h expected %h", outA, e[31:0]); end
    step();
    write = 1'b0;
    sb_q.push_back(64'hAA22CC44);
    @(negedge clk);
    compared++; e = sb_q.pop_front();
    if (outA !== e[31:0]) begin mismatched++; $display("FAIL byteen_zero_after: got %h expected %h", outA, e[31:0]); end
    step();
  endtask

  task automatic test_bypass_off;
    write = 1'b1; waddr = 5'd3; win = 32'h1; ben = 4'hF;
    step();
    win = 32'h2; ra = 5'd3;
    sb_q.push_back(64'h1); sb_q.push_back(64'h2);
    @(negedge clk);
    compared++; e = sb_q.pop_front();
    if (oA1 !== e[31:0]) begin mismatched++; $display("FAIL nobypass_write_cycle: got %h expected %h", oA1, e[31:0]); end
    compared++; e = sb_q.pop_front();
    if (outA !== e[31:0]) begin mismatched++; $display("FAIL bypass_write_cycle: got %h expected %h", outA, e[31:0]); end
    step();
    write = 1'b0;
    sb_q.push_back(64'h2);
    @(negedge clk);
    compared++; e = sb_q.pop_front();
    if (oA1 !== e[31:0]) begin mismatched++; $display("FAIL nobypass_next_cycle: got %h expected %h", oA1, e[31:0]); end
    step();
  endtask

  task automatic test_dual_port;
    write = 1'b0; ra = 5'd7; rb = 5'd7;
    sb_q.push_back(64'hAA22CC44); sb_q.push_back(64'hAA22CC44);
    @(negedge clk);
    compared++; e = sb_q.pop_front();
    if (outA !== e[31:0]) begin mismatched++; $display("FAIL dual_same_A: got %h expected %h", outA, e[31:0]); end
    compared++; e = sb_q.pop_front();
    if (outB !== e[31:0]) begin mismatched++; $display("FAIL dual_same_B: got %h expected %h", outB, e[31:0]); end
    step();
    ra = 5'd5; rb = 5'd3;
    sb_q.push_back(64'h22100002); sb_q.push_back(64'h2);
    @(negedge clk);
    compared++; e = sb_q.pop_front();
    if (outA !== e[31:0]) begin mismatched++; $display("FAIL dual_diff_A: got %h expected %h", outA, e[31:0]); end
    compared++; e = sb_q.pop_front();
    if (outB !== e[31:0]) begin mismatched++; $display("FAIL dual_diff_B: got %h expected %h", outB, e[31:0]); end
    step();
  endtask

  task automatic test_async_pulse;
    write = 1'b1; waddr = 5'd4; win = 32'h00001234; ben = 4'hF; ra = 5'd4;
    step();
    write = 1'b0;
    reset = 1'b1;
    sb_q.push_back(64'h0);
    #2;
    compared++; e = sb_q.pop_front();
    if (outA !== e[31:0]) begin mismatched++; $display("FAIL pulse_forced_zero: got %h expected %h", outA, e[31:0]); end
    reset = 1'b0;
    sb_q.push_back(64'h1234);
    @(negedge clk);
    compared++; e = sb_q.pop_front();
    if (outA !== e[31:0]) begin mismatched++; $display("FAIL pulse_storage_kept: got %h expected %h", outA, e[31:0]); end
    step();
  endtask

  task automatic test_reset_fill;
    ben = 4'hF;
    for (int i = 1; i < 32; i++) begin
      write = 1'b1; waddr = 5'(i); win = 32'(i);
      step();
    end
    write = 1'b0; ra = 5'd9; rb = 5'd31;
    sb_q.push_back(64'd9); sb_q.push_back(64'd31);
    @(negedge clk);
    compared++; e = sb_q.pop_front();
    if (outA !== e[31:0]) begin mismatched++; $display("FAIL fill_reg9: got %h expected %h", outA, e[31:0]); end
    compared++; e = sb_q.pop_front();
    if (outB !== e[31:0]) begin mismatched++; $display("FAIL fill_reg31: got %h expected %h", outB, e[31:0]); end
    step();
    reset = 1'b1; write = 1'b1; waddr = 5'd9; win = 32'h55;
    sb_q.push_back(64'h0); sb_q.push_back(64'h0);
    @(negedge clk);
    compared++; e = sb_q.pop_front();
    if (outA !== e[31:0]) begin mismatched++; $display("FAIL fill_during_reset_A: got %h expected %h", outA, e[31:0]); end
    compared++; e = sb_q.pop_front();
    if (outB !== e[31:0]) begin mismatched++; $display("FAIL fill_during_reset_B: got %h expected %h", outB, e[31:0]); end
    step();
    reset = 1'b0; write = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ra = 5'(i); rb = 5'(31 - i);
      sb_q.push_back(64'h0); sb_q.push_back(64'h0);
      @(negedge clk);
      compared++; e = sb_q.pop_front();
      if (outA !== e[31:0]) begin mismatched++; $display("FAIL cleared_A[%0d]: got %h expected %h", i, outA, e[31:0]); end
      compared++; e = sb_q.pop_front();
      if (oA1 !== e[31:0]) begin mismatched++; $display("FAIL cleared_nobypass_A[%0d]: got %h expected %h", i, oA1, e[31:0]); end
    end
    step();
    write = 1'b1; waddr = 5'd9; win = 32'hCAFE0000; ben = 4'b1100;
    step();
    write = 1'b0; ra = 5'd9;
    sb_q.push_back(64'hCAFE0000);
    @(negedge clk);
    compared++; e = sb_q.pop_front();
    if (outA !== e[31:0]) begin mismatched++; $display("FAIL first_write_after_reset: got %h expected %h", outA, e[31:0]); end
    step();
  endtask

  task automatic test_wide;
    w64 = 1'b1; waddr3 = 3'd7; win64 = 64'h0123456789ABCDEF; ben8 = 8'hFF; ra3 = 3'd7; rb3 = 3'd7;
    step();
    w64 = 1'b0;
    sb_q.push_back(64'h0123456789ABCDEF); sb_q.push_back(64'h0123456789ABCDEF);
    @(negedge clk);
    compared++; e = sb_q.pop_front();
    if (oA2 !== e) begin mismatched++; $display("FAIL wide_A: got %h expected %h", oA2, e); end
    compared++; e = sb_q.pop_front();
    if (oB2 !== e) begin mismatched++; $display("FAIL wide_B: got %h expected %h", oB2, e); end
    step();
    w64 = 1'b1; win64 = 64'hFFFFFFFFFFFFFFFF; ben8 = 8'b1000_0001;
    step();
    w64 = 1'b0;
    sb_q.push_back(64'hFF23456789ABCDFF);
    @(negedge clk);
    compared++; e = sb_q.pop_front();
    if (oA2 !== e) begin mismatched++; $display("FAIL wide_partial: got %h expected %h", oA2, e); end
    step();
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_zero_reg();
    test_byte_enable();
    test_bypass_off();
    test_dual_port();
    test_async_pulse();
    test_reset_fill();
    test_wide();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter WIDTH, default 32: bit width of every register; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 5: address width; the block SHALL hold DEPTH = 2**ADDR_W registers.
REQ-003 Parameter ZERO_REG, default 1: when 1, register 0 SHALL be hardwired to zero.
REQ-004 Parameter BYPASS, default 1: when 1, a read of the register being written SHALL return the new data in the same cycle.
REQ-005 clk  input  1  sole clock; all state updates occur on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-007 write  input  1  write enable for the write port.
REQ-008 writeAddr  input  ADDR_W  register index written.
REQ-009 byteEn  input  WIDTH/8  per-byte write mask; bit i SHALL enable byte i, bits [8i+7:8i].
REQ-010 wordIn  input  WIDTH  write data.
REQ-011 readAddrA  input  ADDR_W  read port A index.
REQ-012 readAddrB  input  ADDR_W  read port B index.
REQ-013 wordOutA  output  WIDTH  read port A data.
REQ-014 wordOutB  output  WIDTH  read port B data.

Function
REQ-015 Reads SHALL be combinational with zero-cycle latency: wordOutX = reg[readAddrX] from current storage, subject to REQ-018 to REQ-020.
REQ-016 On a rising clk edge with reset=0 and write=1, each byte i of reg[writeAddr] with byteEn[i]=1 SHALL take wordIn byte i; bytes with byteEn[i]=0 SHALL keep their value.
REQ-017 write=0 or byteEn=0 SHALL leave all storage unchanged.
REQ-018 ZERO_REG=1: writes to address 0 SHALL be discarded, and a read of address 0 SHALL return 0 even with bypass active.
REQ-019 BYPASS=1, reset=0, write=1, readAddrX==writeAddr (and not a discarded address-0 write): wordOutX SHALL return the merged value, i.e. enabled bytes from wordIn and the other bytes from storage.
REQ-020 BYPASS=0: the read ports SHALL return the pre-edge storage value, and the new value SHALL be visible from the cycle after the write edge.
REQ-021 Both ports SHALL operate independently; readAddrA==readAddrB SHALL return identical data on both ports.
REQ-022 The block SHALL contain exactly one write port; no write collision case exists.
REQ-023 Addresses SHALL cover 0..DEPTH-1 fully, with no out-of-range handling.
REQ-024 Every rising edge SHALL perform at most one register update.

Reset
REQ-025 On a rising clk edge with reset=1, every register SHALL become 0.
REQ-026 Reset SHALL take priority over write: a write presented in the reset cycle SHALL be lost.
REQ-027 While reset=1, wordOutA and wordOutB SHALL be forced to 0 combinationally, and bypass SHALL be suppressed.
REQ-028 Reset asserted between writes SHALL clear all prior contents; the first post-reset write SHALL behave per REQ-016.
REQ-029 The block SHALL have no asynchronous reset path; a reset pulse with no clk edge SHALL not alter storage.

Verification
REQ-030 Default parameters, reset 1 cycle, then write reg 5 = 32'h22100002 with byteEn=4'hF; the next cycle readAddrA=5 -> wordOutA = 32'h22100002.
REQ-031 Write reg 0 = 32'hFFFFFFFF (ZERO_REG=1) -> wordOutA=0 with readAddrA=0, in both the write cycle and the following cycle.
REQ-032 reg 7 = 32'hAABBCCDD; write reg 7 with wordIn=32'h11223344 and byteEn=4'b0101 -> result 32'hAA22CC44; with BYPASS=1 wordOutB shows 32'hAA22CC44 in the write cycle.
REQ-033 BYPASS=0 instance: reg 3 = 32'h1; write reg 3 = 32'h2 with readAddrA=3 -> wordOutA=32'h1 in the write cycle and 32'h2 in the next cycle.
REQ-034 Fill regs 1..31 with their own index, then assert reset together with write reg 9 = 32'h55 -> wordOutA and wordOutB are 0 during reset, and every register reads 0 after reset.
REQ-035 WIDTH=64, ADDR_W=3 instance: write reg 7 = 64'h0123456789ABCDEF with all bytes enabled -> readback matches on both ports.
